vga_sync_rx: RTL and testbench

Receive-side VGA timing recovery. The block watches incoming `hsync`/`vsync` from the display path (pixel-clock domain) and measures the line period. It locks when the period is stable, then regenerates pixel coordinates and a data-enable. It is the checker/consumer counterpart of the horizontal/vertical counter chain, so captured or looped-back video can be validated and addressed.

---
 rtl/vga_sync_rx.sv | 178 +++++++++++++++++
 tb/tb_vga_sync_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing recovery. Measures the hsync period, locks onto a stable
// line length, then regenerates pixel coordinates and a data-enable from the syncs.
module vga_sync_rx #(
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int H_START    = 144,
    parameter int H_ACTIVE   = 640,
    parameter int V_START    = 35,
    parameter int V_ACTIVE   = 480,
    parameter int LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       locked,
    output logic       frame_ok,
    output logic [9:0] line_len
);

    typedef enum logic [1:0] {SEARCH, MEASURE, TRACK, LOCKED} state_t;

    localparam logic        HS_ACT  = (HS_POL != 0);
    localparam logic        VS_ACT  = (VS_POL != 0);
    localparam logic [9:0]  CNT_MAX = 10'd1023;
    localparam logic [9:0]  H_OFF   = 10'(H_START);
    localparam logic [9:0]  V_OFF   = 10'(V_START);
    localparam logic [10:0] H_LO    = 11'(H_START);
    localparam logic [10:0] H_HI    = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO    = 11'(V_START);
    localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);
    localparam logic [3:0]  LOCK_M  = 4'(LOCK_LINES);

    state_t     state_q, state_d;
    logic [9:0] ref_q, ref_d;
    logic [3:0] match_q, match_d;
    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       vs_pending_q, vs_pending_d;
    logic       locked_q, locked_d;
    logic       frame_ok_q, frame_ok_d;
    logic       de_q, de_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [9:0] line_len_q, line_len_d;

    logic       hs_on, vs_on;
    logic       hs_edge, vs_edge;
    logic       h_sat, timeout, vs_hit, act;
    logic [9:0] len;

    // An edge is the first sample at the active level after an inactive one.
    assign hs_on   = (hsync == HS_ACT);
    assign vs_on   = (vsync == VS_ACT);
    assign hs_edge = hs_on && (hs_prev_q != HS_ACT);
    assign vs_edge = vs_on && (vs_prev_q != VS_ACT);
    assign h_sat   = (h_cnt_q == CNT_MAX);
    assign len     = h_sat ? CNT_MAX : h_cnt_q + 10'd1;
    assign timeout = (state_q != SEARCH) && h_sat;
    assign vs_hit  = vs_pending_q || vs_edge;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            hs_prev_q    <= ~HS_ACT;
            vs_prev_q    <= ~VS_ACT;
            h_cnt_q      <= CNT_MAX;
            v_cnt_q      <= '0;
            vs_pending_q <= 1'b0;
            locked_q     <= 1'b0;
            frame_ok_q   <= 1'b0;
            de_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            line_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            vs_pending_q <= vs_pending_d;
            locked_q     <= locked_d;
            frame_ok_q   <= frame_ok_d;
            de_q         <= de_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_len_q   <= line_len_d;
        end
    end

    // Reference length and match count are only read after MEASURE has loaded them.
    always_ff @(posedge clk) begin
        ref_q   <= ref_d;
        match_q <= match_d;
    end

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        match_d = match_q;
        if (timeout) begin
            state_d = SEARCH;
        end else if (hs_edge) begin
            unique case (state_q)
                SEARCH: begin
                    state_d = MEASURE;
                end
                MEASURE: begin
                    ref_d   = len;
                    match_d = 4'd1;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (len == ref_q) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == LOCK_M) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        ref_d   = len;
                        match_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (len != ref_q) begin
                        state_d = TRACK;
                        ref_d   = len;
                        match_d = 4'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        hs_prev_d    = hsync;
        vs_prev_d    = vsync;
        h_cnt_d      = hs_edge ? 10'd0 : (h_sat ? h_cnt_q : h_cnt_q + 10'd1);
        v_cnt_d      = v_cnt_q;
        vs_pending_d = vs_pending_q || vs_edge;
        if (hs_edge) begin
            vs_pending_d = 1'b0;
            if (vs_hit) begin
                v_cnt_d = '0;
            end else if (v_cnt_q != CNT_MAX) begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end

        line_len_d = (hs_edge && state_q != SEARCH && !timeout) ? len : line_len_q;

        // frame_ok needs a frame boundary observed while locked and drops with lock.
        locked_d   = (state_d == LOCKED);
        frame_ok_d = locked_d && (frame_ok_q || (hs_edge && vs_hit));

        act = frame_ok_q
              && ({1'b0, h_cnt_q} >= H_LO) && ({1'b0, h_cnt_q} < H_HI)
              && ({1'b0, v_cnt_q} >= V_LO) && ({1'b0, v_cnt_q} < V_HI);
        de_d = act && !timeout;
        x_d  = act ? h_cnt_q - H_OFF : x_q;
        y_d  = act ? v_cnt_q - V_OFF : y_q;
    end

    assign x        = x_q;
    assign y        = y_q;
    assign de       = de_q;
    assign locked   = locked_q;
    assign frame_ok = frame_ok_q;
    assign line_len = line_len_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx: small video timing, one active-low and one active-high
// instance fed the same syncs, checked against a line/run-length reference model.
module tb_vga_sync_rx;
    localparam int HS = 10, HA = 20, VS = 3, VA = 5, LK = 4;
    localparam int FR = 12, VSW = 2, LINE = 40, HSW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hs_on = 1'b0, vs_on = 1'b0;
    logic hsync1, vsync1, hsync2, vsync2;
    logic [9:0] x1, y1, len1, x2, y2, len2;
    logic de1, locked1, fok1, de2, locked2, fok2;

    assign hsync1 = ~hs_on;
    assign vsync1 = ~vs_on;
    assign hsync2 = hs_on;
    assign vsync2 = vs_on;

    vga_sync_rx #(.HS_POL(0), .VS_POL(0), .H_START(HS), .H_ACTIVE(HA), .V_START(VS),
                  .V_ACTIVE(VA), .LOCK_LINES(LK)) dut1 (
        .clk(clk), .rst_n(rst_n), .hsync(hsync1), .vsync(vsync1), .x(x1), .y(y1),
        .de(de1), .locked(locked1), .frame_ok(fok1), .line_len(len1));

    vga_sync_rx #(.HS_POL(1), .VS_POL(1), .H_START(HS), .H_ACTIVE(HA), .V_START(VS),
                  .V_ACTIVE(VA), .LOCK_LINES(LK)) dut2 (
        .clk(clk), .rst_n(rst_n), .hsync(hsync2), .vsync(vsync2), .x(x2), .y(y2),
        .de(de2), .locked(locked2), .frame_ok(fok2), .line_len(len2));

    always #5 clk = ~clk;

    int tests = 0, fails = 0, g_line = 0;

    // Reference state: cycles since last line start, run of equal line lengths.
    int m_pos = 1023, m_lines = 0, m_edges = 0, m_run = 0, m_last = 0;
    logic m_hs_prev = 0, m_vs_prev = 0, m_vpend = 0, m_locked = 0, m_fok = 0, m_de = 0;
    logic [9:0] m_x = 0, m_y = 0, m_len = 0;

    task automatic model_step();
        logic he, ve, act;
        int len;
        if (!rst_n) begin
            m_pos = 1023; m_lines = 0; m_edges = 0; m_run = 0; m_last = 0;
            m_hs_prev = 0; m_vs_prev = 0; m_vpend = 0; m_locked = 0; m_fok = 0;
            m_de = 0; m_x = 0; m_y = 0; m_len = 0;
            return;
        end
        he = hs_on && !m_hs_prev;
        ve = vs_on && !m_vs_prev;
        m_hs_prev = hs_on;
        m_vs_prev = vs_on;
        act = m_fok && m_pos >= HS && m_pos < HS + HA && m_lines >= VS && m_lines < VS + VA;
        m_de = act;
        if (act) begin
            m_x = 10'(m_pos - HS);
            m_y = 10'(m_lines - VS);
        end
        len = (m_pos + 1 > 1023) ? 1023 : m_pos + 1;
        if (m_edges != 0 && m_pos == 1023) begin
            m_edges = 0; m_run = 0; m_locked = 0; m_de = 0;
        end else if (he) begin
            if (m_edges == 0) begin
                m_edges = 1;
            end else begin
                m_len = 10'(len);
                m_run = (m_edges == 2 && len == m_last) ? m_run + 1 : 1;
                m_last = len;
                m_edges = 2;
                m_locked = (m_run >= LK);
            end
        end
        if (he) begin
            if (m_vpend || ve) begin
                m_lines = 0; m_vpend = 0; m_fok = m_locked;
            end else if (m_lines < 1023) begin
                m_lines = m_lines + 1;
            end
        end else if (ve) begin
            m_vpend = 1;
        end
        if (!m_locked) m_fok = 0;
        m_pos = he ? 0 : (m_pos < 1023 ? m_pos + 1 : 1023);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input int len, input int c, input int hw);
        hs_on = (c < hw);
        vs_on = (g_line < VSW);
        step();
        if (c == len - 1) g_line = (g_line + 1) % FR;
    endtask

    task automatic test_reset();
        rst_n = 0; hs_on = 0; vs_on = 0;
        repeat (3) step();
        tests++; if (x1 !== 10'd0) begin fails++; $display("FAIL reset_x got %0d exp 0", x1); end
        tests++; if (y1 !== 10'd0) begin fails++; $display("FAIL reset_y got %0d exp 0", y1); end
        tests++; if (de1 !== 1'b0) begin fails++; $display("FAIL reset_de got %b exp 0", de1); end
        tests++; if (locked1 !== 1'b0) begin fails++; $display("FAIL reset_locked got %b exp 0", locked1); end
        tests++; if (fok1 !== 1'b0) begin fails++; $display("FAIL reset_frame_ok got %b exp 0", fok1); end
        tests++; if (len1 !== 10'd0) begin fails++; $display("FAIL reset_line_len got %0d exp 0", len1); end
        tests++; if ({x2, y2, de2, locked2, fok2, len2} !== 33'd0) begin
            fails++; $display("FAIL reset_pol1 got %h exp 0", {x2, y2, de2, locked2, fok2, len2});
        end
        rst_n = 1;
        g_line = 0;
    endtask

    task automatic test_standard();
        int edge_n = 0, lock_edge = 0, de_cnt = 0;
        logic pl = 0, got_first = 0;
        logic [9:0] fx = 0, fy = 0, lx = 0, ly = 0;
        g_line = 0;
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < FR; l++)
                for (int c = 0; c < LINE; c++) begin
                    drive(LINE, c, HSW);
                    if (c == 0) edge_n++;
                    if (locked1 && !pl && lock_edge == 0) lock_edge = edge_n;
                    pl = locked1;
                    if (f == 2 && de1) begin
                        de_cnt++;
                        if (!got_first) begin got_first = 1; fx = x1; fy = y1; end
                        lx = x1; ly = y1;
                    end
                    tests++; if (de1 !== m_de) begin fails++; $display("FAIL std_de t=%0t got %b exp %b", $time, de1, m_de); end
                    tests++; if (x1 !== m_x) begin fails++; $display("FAIL std_x t=%0t got %0d exp %0d", $time, x1, m_x); end
                    tests++; if (y1 !== m_y) begin fails++; $display("FAIL std_y t=%0t got %0d exp %0d", $time, y1, m_y); end
                    tests++; if (locked1 !== m_locked) begin fails++; $display("FAIL std_locked t=%0t got %b exp %b", $time, locked1, m_locked); end
                    tests++; if (fok1 !== m_fok) begin fails++; $display("FAIL std_frame_ok t=%0t got %b exp %b", $time, fok1, m_fok); end
                    tests++; if (len1 !== m_len) begin fails++; $display("FAIL std_line_len t=%0t got %0d exp %0d", $time, len1, m_len); end
                end
        tests++; if (lock_edge != 5) begin fails++; $display("FAIL std_lock_edge got %0d exp 5", lock_edge); end
        tests++; if (de_cnt != HA * VA) begin fails++; $display("FAIL std_de_count got %0d exp %0d", de_cnt, HA * VA); end
        tests++; if (fx !== 10'd0 || fy !== 10'd0) begin fails++; $display("FAIL std_first_xy got %0d,%0d exp 0,0", fx, fy); end
        tests++; if (lx !== 10'(HA - 1) || ly !== 10'(VA - 1)) begin
            fails++; $display("FAIL std_last_xy got %0d,%0d exp %0d,%0d", lx, ly, HA - 1, VA - 1);
        end
        tests++; if (len1 !== 10'(LINE)) begin fails++; $display("FAIL std_len_final got %0d exp %0d", len1, LINE); end
    endtask

    task automatic test_polarity();
        for (int l = 0; l < FR; l++)
            for (int c = 0; c < LINE; c++) begin
                drive(LINE, c, HSW);
                tests++; if (de2 !== m_de) begin fails++; $display("FAIL pol_de t=%0t got %b exp %b", $time, de2, m_de); end
                tests++; if (x2 !== m_x || y2 !== m_y) begin fails++; $display("FAIL pol_xy t=%0t got %0d,%0d exp %0d,%0d", $time, x2, y2, m_x, m_y); end
                tests++; if (locked2 !== m_locked || fok2 !== m_fok) begin
                    fails++; $display("FAIL pol_lock t=%0t got %b%b exp %b%b", $time, locked2, fok2, m_locked, m_fok);
                end
                tests++; if (len2 !== m_len) begin fails++; $display("FAIL pol_line_len t=%0t got %0d exp %0d", $time, len2, m_len); end
            end
    endtask

    task automatic test_lock_in();
        int lens[12] = '{40, 40, 40, 39, 40, 40, 40, 40, 40, 40, 40, 40};
        int edge_n = 0, lock_edge = 0;
        logic pl = 0;
        rst_n = 0; hs_on = 0; vs_on = 0;
        step();
        rst_n = 1;
        g_line = 0;
        for (int l = 0; l < 12; l++)
            for (int c = 0; c < lens[l]; c++) begin
                drive(lens[l], c, HSW);
                if (c == 0) edge_n++;
                if (locked1 && !pl && lock_edge == 0) lock_edge = edge_n;
                pl = locked1;
                tests++; if (locked1 !== m_locked) begin fails++; $display("FAIL lockin_locked t=%0t got %b exp %b", $time, locked1, m_locked); end
                tests++; if (len1 !== m_len) begin fails++; $display("FAIL lockin_line_len t=%0t got %0d exp %0d", $time, len1, m_len); end
            end
        tests++; if (lock_edge != 9) begin fails++; $display("FAIL lockin_edge got %0d exp 9", lock_edge); end
    endtask

    task automatic test_glitch();
        int len;
        for (int n = 0; n < 3 * FR; n++) begin
            len = (n == FR + 5) ? 39 : LINE;
            for (int c = 0; c < len; c++) begin
                drive(len, c, HSW);
                if (n == FR + 6 && c == 0) begin
                    tests++; if (locked1 !== 1'b0 || fok1 !== 1'b0) begin
                        fails++; $display("FAIL glitch_drop got locked=%b frame_ok=%b exp 0,0", locked1, fok1);
                    end
                    tests++; if (len1 !== 10'd39) begin fails++; $display("FAIL glitch_len got %0d exp 39", len1); end
                end
                if (n == FR + 7 && c == 0) begin
                    tests++; if (len1 !== 10'd40) begin fails++; $display("FAIL glitch_len_after got %0d exp 40", len1); end
                end
                if (n >= FR + 6 && n < 2 * FR) begin
                    tests++; if (de1 !== 1'b0) begin fails++; $display("FAIL glitch_de_off t=%0t got %b exp 0", $time, de1); end
                end
                tests++; if (locked1 !== m_locked || fok1 !== m_fok) begin
                    fails++; $display("FAIL glitch_lock t=%0t got %b%b exp %b%b", $time, locked1, fok1, m_locked, m_fok);
                end
                tests++; if (de1 !== m_de) begin fails++; $display("FAIL glitch_de t=%0t got %b exp %b", $time, de1, m_de); end
                tests++; if (len1 !== m_len) begin fails++; $display("FAIL glitch_line_len t=%0t got %0d exp %0d", $time, len1, m_len); end
            end
        end
    endtask

    task automatic test_hsync_stop();
        drive(LINE, 0, HSW);
        hs_on = 0; vs_on = 0;
        for (int k = 1; k <= 1100; k++) begin
            step();
            if (k == 1023) begin
                tests++; if (locked1 !== 1'b1) begin fails++; $display("FAIL stop_hold got %b exp 1", locked1); end
            end
            if (k == 1024) begin
                tests++; if (locked1 !== 1'b0) begin fails++; $display("FAIL stop_timeout got %b exp 0", locked1); end
            end
            if (k >= 1024) begin
                tests++; if (de1 !== 1'b0 || fok1 !== 1'b0) begin
                    fails++; $display("FAIL stop_de t=%0t got de=%b frame_ok=%b exp 0,0", $time, de1, fok1);
                end
            end
            tests++; if (locked1 !== m_locked || de1 !== m_de) begin
                fails++; $display("FAIL stop_model t=%0t got %b%b exp %b%b", $time, locked1, de1, m_locked, m_de);
            end
        end
        g_line = 1;
    endtask

    task automatic test_reset_mid();
        int edge_n = 0, lock_edge = 0;
        logic pl = 0;
        g_line = 0;
        for (int l = 0; l < 2 * FR + 5; l++)
            for (int c = 0; c < LINE; c++) drive(LINE, c, HSW);
        for (int c = 0; c < 15; c++) drive(LINE, c, HSW);
        tests++; if (de1 !== m_de) begin fails++; $display("FAIL rstmid_pre_de got %b exp %b", de1, m_de); end
        rst_n = 0;
        drive(LINE, 15, HSW);
        rst_n = 1;
        tests++; if ({x1, y1, de1, locked1, fok1, len1} !== 33'd0) begin
            fails++; $display("FAIL rstmid_outputs got %h exp 0", {x1, y1, de1, locked1, fok1, len1});
        end
        for (int c = 16; c < LINE; c++) drive(LINE, c, HSW);
        for (int l = 0; l < 8; l++)
            for (int c = 0; c < LINE; c++) begin
                drive(LINE, c, HSW);
                if (c == 0) edge_n++;
                if (locked1 && !pl && lock_edge == 0) lock_edge = edge_n;
                pl = locked1;
                tests++; if (locked1 !== m_locked || fok1 !== m_fok || de1 !== m_de) begin
                    fails++; $display("FAIL rstmid_model t=%0t got %b%b%b exp %b%b%b", $time, locked1, fok1, de1, m_locked, m_fok, m_de);
                end
                tests++; if (x1 !== m_x || y1 !== m_y || len1 !== m_len) begin
                    fails++; $display("FAIL rstmid_data t=%0t got %0d,%0d,%0d exp %0d,%0d,%0d", $time, x1, y1, len1, m_x, m_y, m_len);
                end
            end
        tests++; if (lock_edge != 5) begin fails++; $display("FAIL rstmid_relock_edge got %0d exp 5", lock_edge); end
    endtask

    task automatic test_random();
        int len, hw;
        for (int l = 0; l < 60; l++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 50)) : LINE;
            hw = int'($urandom_range(1, 6));
            for (int c = 0; c < len; c++) begin
                drive(len, c, hw);
                tests++; if (de1 !== m_de || x1 !== m_x || y1 !== m_y) begin
                    fails++; $display("FAIL rand_video t=%0t got %b,%0d,%0d exp %b,%0d,%0d", $time, de1, x1, y1, m_de, m_x, m_y);
                end
                tests++; if (locked1 !== m_locked || fok1 !== m_fok) begin
                    fails++; $display("FAIL rand_lock t=%0t got %b%b exp %b%b", $time, locked1, fok1, m_locked, m_fok);
                end
                tests++; if (len1 !== m_len) begin fails++; $display("FAIL rand_line_len t=%0t got %0d exp %0d", $time, len1, m_len); end
                tests++; if (de2 !== m_de || locked2 !== m_locked) begin
                    fails++; $display("FAIL rand_pol t=%0t got %b%b exp %b%b", $time, de2, locked2, m_de, m_locked);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_standard();
        test_polarity();
        test_lock_in();
        test_glitch();
        test_hsync_stop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
